// File: rtl/lsu.sv
// Load/store unit: one request at a time to a word-addressed valid/ready memory port.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        done_o,
    output logic [31:0] load_result_o,
    output logic        misaligned_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        is_load_q, is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, store_data_q;
    logic [31:0] load_result_q, load_result_d;
    logic        mis_q, mis_d;
    logic        mis_in;
    logic        accept;
    logic        store_eff;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [3:0]  strb;
    logic [31:0] wdata;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_in = ((funct3_i[1:0] == 2'b01) & addr_i[0])
                  | (funct3_i[1] & (addr_i[1:0] != 2'b00));
`else
    assign mis_in = 1'b0;
`endif

    assign accept    = (state_q == S_IDLE) & req_valid_i;
    // A request flagged as both load and store behaves as a load.
    assign store_eff = is_store_q & ~is_load_q;

    always_comb begin
        state_d       = state_q;
        mis_d         = mis_q;
        load_result_d = load_result_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    mis_d = (is_load_i | is_store_i) & mis_in;
                    if ((is_load_i | is_store_i) && !mis_in) state_d = S_REQ;
                    else                                     state_d = S_DONE;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d = S_DONE;
                    if (is_load_q) load_result_d = load_ext;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_sel = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                strb  = 4'b0001 << addr_q[1:0];
                wdata = {4{store_data_q[7:0]}};
            end
            2'b01: begin
                strb  = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data_q[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = store_data_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            is_load_q     <= 1'b0;
            is_store_q    <= 1'b0;
            funct3_q      <= 3'd0;
            addr_q        <= 32'd0;
            store_data_q  <= 32'd0;
            load_result_q <= 32'd0;
            mis_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_result_q <= load_result_d;
            mis_q         <= mis_d;
            if (accept) begin
                is_load_q    <= is_load_i;
                is_store_q   <= is_store_i;
                funct3_q     <= funct3_i;
                addr_q       <= addr_i;
                store_data_q <= store_data_i;
            end
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_addr_o      = {addr_q[31:2], 2'b00};
    assign mem_we_o        = mem_req_valid_o & store_eff;
    assign mem_wstrb_o     = mem_we_o ? strb : 4'b0000;
    assign mem_wdata_o     = store_eff ? wdata : 32'd0;
    assign done_o          = (state_q == S_DONE);
    assign load_result_o   = load_result_q;
    assign misaligned_o    = done_o & mis_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver pushes expected memory requests and completions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o;
    logic        is_load_i, is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        done_o;
    logic [31:0] load_result_o;
    logic        misaligned_o;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
        .done_o(done_o), .load_result_o(load_result_o), .misaligned_o(misaligned_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        logic [31:0] lr;
        logic        mis;
    } dexp_t;

    mexp_t       mq[$];
    dexp_t       dq[$];
    mexp_t       me;
    dexp_t       de;
    logic [31:0] model_lr = 32'd0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a[1:0])) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    // Monitor: compares every memory handshake and every completion with the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!mem_req_valid_o) chk("we_without_valid", {31'd0, mem_we_o}, 32'd0);
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: got addr %h expected none", mem_addr_o);
                end else begin
                    me = mq.pop_front();
                    chk("mem_addr", mem_addr_o, me.addr);
                    chk("mem_we", {31'd0, mem_we_o}, {31'd0, me.we});
                    chk("mem_wstrb", {28'd0, mem_wstrb_o}, {28'd0, me.strb});
                    if (me.we) chk("mem_wdata", mem_wdata_o, me.wdata);
                end
            end
            if (done_o) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    de = dq.pop_front();
                    chk("load_result", load_result_o, de.lr);
                    chk("misaligned", {31'd0, misaligned_o}, {31'd0, de.mis});
                end
            end
        end
    end

    task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int d, input int r, input bit early);
        bit    mem_path, is_st, mis;
        mexp_t m;
        mem_path = ld | st;
        is_st    = st & ~ld;
        mis      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mem_path) begin
            if (f3[1:0] == 2'b01)  mis = a[0];
            else if (f3[1])        mis = (a[1:0] != 2'b00);
        end
`endif
        if (mem_path && !mis) begin
            m.addr  = a & 32'hFFFF_FFFC;
            m.we    = is_st;
            m.strb  = 4'b0000;
            m.wdata = 32'd0;
            if (is_st) begin
                if (f3[1:0] == 2'b00) begin
                    m.strb  = 4'(1 << a[1:0]);
                    m.wdata = sd[7:0] * 32'h0101_0101;
                end else if (f3[1:0] == 2'b01) begin
                    m.strb  = a[1] ? 4'b1100 : 4'b0011;
                    m.wdata = sd[15:0] * 32'h0001_0001;
                end else begin
                    m.strb  = 4'b1111;
                    m.wdata = sd;
                end
            end else begin
                model_lr = load_val(f3, a, rd);
            end
            mq.push_back(m);
        end
        dq.push_back('{model_lr, mis});

        @(posedge clk); #1;
        req_valid_i = 1'b1; is_load_i = ld; is_store_i = st;
        funct3_i = f3; addr_i = a; store_data_i = sd;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0; is_load_i = 1'($urandom); is_store_i = 1'($urandom);
        funct3_i = 3'($urandom); addr_i = $urandom; store_data_i = $urandom;
        if (mem_path && !mis) begin
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                chk("mem_valid_held", {31'd0, mem_req_valid_o}, 32'd1);
                chk("mem_addr_held", mem_addr_o, m.addr);
                @(posedge clk); #1;
            end
            mem_req_ready_i = 1'b1;
            if (early) begin
                mem_rsp_valid_i = 1'b1;
                mem_rdata_i     = ~rd;
            end
            @(negedge clk);
            chk("mem_valid_at_hs", {31'd0, mem_req_valid_o}, 32'd1);
            @(posedge clk); #1;
            mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
            for (int i = 0; i < r; i++) begin
                @(posedge clk); #1;
            end
            mem_rsp_valid_i = 1'b1; mem_rdata_i = rd;
            @(posedge clk); #1;
            mem_rsp_valid_i = 1'b0; mem_rdata_i = $urandom;
        end
        @(negedge clk);
        chk("done_latency", {31'd0, done_o}, 32'd1);
        if (!(mem_path && !mis)) chk("no_mem_req", {31'd0, mem_req_valid_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        funct3_i = 3'd0; addr_i = 32'd0; store_data_i = 32'd0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 32'd0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_req_valid_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_load_result", load_result_o, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LB lane 3, sign extension, minimum latency
        do_req(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        // LHU with five cycles of backpressure
        do_req(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 5, 0, 0);
        // SB and SH keep the previous load result
        do_req(0, 1, 3'b000, 32'h0000_0101, 32'hAABB_CC5A, 32'h0, 0, 1, 0);
        do_req(0, 1, 3'b001, 32'h0000_0102, 32'h1234_5678, 32'h0, 1, 0, 0);
        do_req(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        do_req(0, 0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);
        do_req(1, 1, 3'b001, 32'h0000_0042, 32'h1111_2222, 32'h8001_7FFF, 0, 0, 1);

        // Reset while a load waits for its response
        mq.push_back('{32'h0000_0040, 1'b0, 4'b0000, 32'd0});
        @(posedge clk); #1;
        req_valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0;
        funct3_i = 3'b010; addr_i = 32'h0000_0040;
        @(posedge clk); #1;
        req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        mem_req_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("arst_mem_valid", {31'd0, mem_req_valid_o}, 32'd0);
        chk("arst_mem_addr", mem_addr_o, 32'd0);
        chk("arst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("arst_wstrb", {28'd0, mem_wstrb_o}, 32'd0);
        chk("arst_wdata", mem_wdata_o, 32'd0);
        chk("arst_done", {31'd0, done_o}, 32'd0);
        chk("arst_load_result", load_result_o, 32'd0);
        chk("arst_misaligned", {31'd0, misaligned_o}, 32'd0);
        model_lr = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stray_rsp_no_done", {31'd0, done_o}, 32'd0);
            chk("stray_rsp_ready", {31'd0, req_ready_o}, 32'd1);
            @(posedge clk); #1;
        end
        mem_rsp_valid_i = 1'b0;

        for (int n = 0; n < 200; n++) begin
            int          kind;
            bit          ld, st;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            ld = (kind == 1) || (kind >= 2 && kind <= 5);
            st = (kind == 1) || (kind >= 6);
            a  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 31));
            do_req(ld, st, 3'($urandom), a, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        repeat (3) @(posedge clk);
        chk("mem_queue_drained", mq.size(), 32'd0);
        chk("done_queue_drained", dq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the multi-cycle core. It takes one memory-phase request from the control FSM and drives a word-addressed memory port with a valid/ready handshake. For stores it generates the byte strobes and lane-replicated write data. For loads it extracts and sign- or zero-extends the addressed lane and returns it as `load_result`, which the register file writes back under `is_load`.

## Interface
- No parameters. Data and address widths are fixed at 32.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request from the control FSM.
- `req_ready` out 1: high only in IDLE.
- `is_load` in 1: request is a load.
- `is_store` in 1: request is a store.
- `funct3` in 3: RV32I width/sign code.
- `addr` in 32: byte address (ALU result).
- `store_data` in 32: rs2 value.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_we` out 1: write enable.
- `mem_wstrb` out 4: byte strobes. Zero for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rsp_valid` in 1: read data or write acknowledge.
- `mem_rdata` in 32: read word.
- `done` out 1: one-cycle completion pulse.
- `load_result` out 32: extended load value. Held stable until the next accepted request.
- `misaligned` out 1: see Configuration. Valid with `done`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` the unit latches `is_load`, `is_store`, `funct3`, `addr` and `store_data`.
  - If `is_load` or `is_store` is set, go to REQ. Otherwise go to DONE with no memory traffic.
  - If both are set, the request is treated as a load.
- REQ: `mem_req_valid`=1 with all `mem_*` outputs stable. On `mem_req_ready` go to WAIT.
- WAIT: wait for `mem_rsp_valid`. Stores also wait for it (write acknowledge). Then go to DONE.
  - For a load, `load_result` is captured from `mem_rdata` in this same cycle.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Load extraction, by `funct3` (lane = `addr[1:0]`):
  - 000 LB: byte at the lane, sign-extended.
  - 100 LBU: byte at the lane, zero-extended.
  - 001 LH: half at `addr[1]`, sign-extended.
  - 101 LHU: half at `addr[1]`, zero-extended.
  - 010, 011, 110, 111: LW (full word).
- Store generation, by `funct3[1:0]` (`funct3[2]` is ignored):
  - 00 SB: `wstrb` = 1<<`addr[1:0]`; `wdata` = {4{`store_data[7:0]`}}.
  - 01 SH: `wstrb` = 0011 or 1100 by `addr[1]`; `wdata` = {2{`store_data[15:0]`}}.
  - 1x SW: `wstrb` = 1111; `wdata` = `store_data`.
- `mem_we` = latched `is_store`. It is 0 whenever `mem_req_valid` is 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, every other output 0, `load_result`=0.
- Reset mid-operation forces IDLE immediately. The unit does not wait for an outstanding memory response. `mem_rsp_valid` in IDLE is ignored.
- Request accepted at edge T:
  - `mem_req_valid` rises at T+1.
  - With `mem_req_ready`=1 at T+1 and `mem_rsp_valid`=1 at T+2, `done` is high during T+3.
  - Minimum latency is 3 cycles. The non-memory path (neither `is_load` nor `is_store`) takes 1 cycle.
- `mem_req_valid` must not drop, and `mem_*` must not change, until `mem_req_ready` is sampled high. Backpressure of any length is legal.
- A response with `mem_rsp_valid` in the same cycle as the `mem_req_ready` handshake is not expected. If it occurs, it is ignored; only responses seen in WAIT count.
- `req_valid` outside IDLE is ignored. There is no queueing.
- `load_result` is unchanged by stores and by the non-memory path.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - An access with `addr[0]`=1 for a half, or `addr[1:0]`≠0 for a word, skips REQ/WAIT and goes straight to DONE.
  - `misaligned`=1 with `done`. No memory request is issued and `load_result` is unchanged.
- Undefined:
  - `misaligned` is tied to 0.
  - Misaligned halves use `addr[1]`, and misaligned words use the aligned word (low bits dropped).

## Test plan
- LB at `addr`=0x1003, `mem_rdata`=0x80FF_1234 → `mem_addr`=0x1000, `mem_wstrb`=0000, `load_result`=0xFFFF_FF80, `done` at T+3.
- LHU at 0x2002, `mem_rdata`=0xBEEF_0000, with `mem_req_ready` held low for 5 cycles → `mem_req_valid` and `mem_addr` stable throughout, `load_result`=0x0000_BEEF, `done` at T+8.
- SB at 0x0101 with `store_data`=0xAABB_CC5A → `mem_we`=1, `mem_wstrb`=0010, `mem_wdata`=0x5A5A_5A5A. Previous `load_result` retained.
- SH at 0x0102 with `store_data`=0x1234_5678 → `mem_wstrb`=1100, `mem_wdata`=0x5678_5678.
- LW at 0x0006:
  - With `LSU_MISALIGN_TRAP_EN`: `done`+`misaligned` at T+1, `mem_req_valid` never asserted.
  - Without it: `mem_addr`=0x0004, full-word load.
- `rst_n` low during WAIT of a load → all outputs 0 at once. After release, `req_ready`=1, and a stray `mem_rsp_valid` does not produce `done`.
